// File: rtl/cache_mem_pkg.sv
// Shared widths, FSM state and operation encodings for the cache memory responder.
package cache_mem_pkg;

  localparam int BLOCK_W    = 128;
  localparam int MEM_ADDR_W = 28;
  localparam int WORD_W     = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;

endpackage

// File: rtl/mem_block_ram.sv
// Block-wide backing store: synchronous write, registered read, asynchronous clear.
module mem_block_ram
  import cache_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] wIdx_i,
  input  logic [BLOCK_W-1:0]    wData_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] rIdx_i,
  output logic [BLOCK_W-1:0]    rData_o
);

  logic [BLOCK_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [BLOCK_W-1:0] rData_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wIdx_i] <= wData_i;
    end
  end

  // Read data only moves on a read strobe, so it holds across write responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rData_q <= '0;
    end else if (re_i) begin
      rData_q <= mem_q[rIdx_i];
    end
  end

  assign rData_o = rData_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache block interface: one request at a time,
// answered with a registered single-cycle mem_ready after LATENCY cycles.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  mem_reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [BLOCK_W-1:0]    mem_wdata,
  output logic [BLOCK_W-1:0]    mem_rdata,
  output logic                  mem_ready,
  output logic                  prot_err
);

  state_e                state_q;
  op_e                   op_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [BLOCK_W-1:0]    wdata_q;
  logic                  ready_q;
  logic                  protErr_q;

  logic                  reqAny;
  op_e                   reqOp;
  logic [CNT_W-1:0]      cntDec;
  logic                  enterResp;
  op_e                   respOp;
  logic                  ramRe;
  logic [DEPTH_LOG2-1:0] rdIdx;

  // The read strobe fires on the edge that enters S_RESP so that the
  // registered RAM output is valid in the same cycle as mem_ready.
  always_comb begin
    reqAny    = mem_read | mem_write;
    reqOp     = mem_write ? OP_WR : OP_RD;
    cntDec    = cnt_q - CNT_W'(1);
    enterResp = 1'b0;
    respOp    = op_q;
    rdIdx     = addr_q[DEPTH_LOG2-1:0];
    if (state_q == S_IDLE) begin
      enterResp = reqAny && (LATENCY == 1);
      respOp    = reqOp;
      rdIdx     = mem_addr[DEPTH_LOG2-1:0];
    end else if (state_q == S_BUSY) begin
      enterResp = reqAny && (cntDec == '0);
    end
    ramRe = enterResp && (respOp == OP_RD);
  end

  always_ff @(posedge clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_RD;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      protErr_q <= 1'b0;
    end else begin
      ready_q <= enterResp;
      case (state_q)
        S_IDLE: begin
          if (reqAny) begin
            op_q    <= reqOp;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? S_RESP : S_BUSY;
            if (mem_read && mem_write) protErr_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!reqAny) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            protErr_q <= 1'b1;
          end else begin
            cnt_q <= cntDec;
            if (mem_addr != addr_q || reqOp != op_q || (mem_read && mem_write)) protErr_q <= 1'b1;
            if (cntDec == '0) state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  mem_block_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) uRam (
    .clk_i   (clk),
    .rst_ni  (mem_reset_n),
    .we_i    ((state_q == S_RESP) && (op_q == OP_WR)),
    .wIdx_i  (addr_q[DEPTH_LOG2-1:0]),
    .wData_i (wdata_q),
    .re_i    (ramRe),
    .rIdx_i  (rdIdx),
    .rData_o (mem_rdata)
  );

  assign mem_ready = ready_q;
  assign prot_err  = protErr_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench for cache_mem_responder at LATENCY=4 and LATENCY=1.
module tb_cache_mem_responder;
  import cache_mem_pkg::*;

  localparam logic [BLOCK_W-1:0] D1 = 128'hDEADBEEF_00000002_00000001_CAFEF00D;
  localparam logic [BLOCK_W-1:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [BLOCK_W-1:0] D4 = 128'h55AA55AA_00FF00FF_12345678_9ABCDEF0;

  logic                  clk;
  logic                  rstN;
  logic                  rd, wr, rdy, perr;
  logic [MEM_ADDR_W-1:0] addr;
  logic [BLOCK_W-1:0]    wdata, rdata;
  logic                  rd1, wr1, rdy1, perr1;
  logic [MEM_ADDR_W-1:0] addr1;
  logic [BLOCK_W-1:0]    wdata1, rdata1;

  int total = 0;
  int bad   = 0;
  int n;
  int pulses;

  cache_mem_responder #(.LATENCY(4), .DEPTH_LOG2(6)) dut (
    .clk         (clk),
    .mem_reset_n (rstN),
    .mem_read    (rd),
    .mem_write   (wr),
    .mem_addr    (addr),
    .mem_wdata   (wdata),
    .mem_rdata   (rdata),
    .mem_ready   (rdy),
    .prot_err    (perr)
  );

  cache_mem_responder #(.LATENCY(1), .DEPTH_LOG2(6)) dut1 (
    .clk         (clk),
    .mem_reset_n (rstN),
    .mem_read    (rd1),
    .mem_write   (wr1),
    .mem_addr    (addr1),
    .mem_wdata   (wdata1),
    .mem_rdata   (rdata1),
    .mem_ready   (rdy1),
    .prot_err    (perr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [MEM_ADDR_W-1:0] a,
                               input logic [BLOCK_W-1:0] d);
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic applyStimulus1(input logic r, input logic w, input logic [MEM_ADDR_W-1:0] a,
                                input logic [BLOCK_W-1:0] d);
    rd1    = r;
    wr1    = w;
    addr1  = a;
    wdata1 = d;
  endtask

  task automatic checkOutput(input string tag, input logic [BLOCK_W-1:0] obs,
                             input logic [BLOCK_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycles until mem_ready is seen; budget+1 means it never came.
  task automatic waitReady(input int budget, output int cycles);
    cycles = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (rdy === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus1(1'b0, 1'b0, '0, '0);
    repeat (3) step();
    checkOutput("rst_ready", rdy, 1'b0);
    checkOutput("rst_rdata", rdata, '0);
    checkOutput("rst_prot", perr, 1'b0);
    rstN = 1'b1;
    step();

    applyStimulus(1'b0, 1'b1, 28'h0000005, D2);
    step();
    step();
    rstN = 1'b0;
    step();
    checkOutput("midrst_ready", rdy, 1'b0);
    checkOutput("midrst_rdata", rdata, '0);
    checkOutput("midrst_prot", perr, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    rstN = 1'b1;
    step();

    applyStimulus(1'b1, 1'b0, 28'h0000005, '0);
    waitReady(20, n);
    checkOutput("rd5_latency", n, 4);
    checkOutput("rd5_data", rdata, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    checkOutput("rd5_one_pulse", rdy, 1'b0);

    applyStimulus(1'b0, 1'b1, 28'h0000003, D1);
    waitReady(20, n);
    checkOutput("wr3_latency", n, 4);
    checkOutput("wr3_rdata_held", rdata, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();

    applyStimulus(1'b1, 1'b0, 28'h0000003, '0);
    waitReady(20, n);
    checkOutput("rd3_latency", n, 4);
    checkOutput("rd3_data", rdata, D1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();

    // Dirty write-back to 0x41 then fill from 0x01, which aliases to the same block.
    applyStimulus(1'b0, 1'b1, 28'h0000041, D2);
    waitReady(20, n);
    checkOutput("wb_latency", n, 4);
    applyStimulus(1'b1, 1'b0, 28'h0000001, '0);
    waitReady(20, n);
    checkOutput("fill_latency", n, 5);
    checkOutput("fill_alias_data", rdata, D2);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    applyStimulus(1'b1, 1'b0, 28'h0000011, '0);
    waitReady(20, n);
    checkOutput("rd11_latency", n, 4);
    checkOutput("rd11_no_alias", rdata, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    checkOutput("clean_prot", perr, 1'b0);

    applyStimulus(1'b1, 1'b0, 28'h0000003, '0);
    step();
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rdy === 1'b1) pulses++;
    end
    checkOutput("abort_no_ready", pulses, 0);
    checkOutput("abort_prot", perr, 1'b1);
    applyStimulus(1'b1, 1'b0, 28'h0000003, '0);
    waitReady(20, n);
    checkOutput("after_abort_latency", n, 4);
    checkOutput("after_abort_data", rdata, D1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();

    rstN = 1'b0;
    step();
    rstN = 1'b1;
    step();
    checkOutput("prot_cleared", perr, 1'b0);

    applyStimulus(1'b1, 1'b1, 28'h0000007, 128'h1);
    waitReady(20, n);
    checkOutput("coll_latency", n, 4);
    checkOutput("coll_prot", perr, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    applyStimulus(1'b1, 1'b0, 28'h0000007, '0);
    waitReady(20, n);
    checkOutput("coll_readback", rdata, 128'h1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();

    rstN = 1'b0;
    step();
    rstN = 1'b1;
    step();
    applyStimulus(1'b0, 1'b1, 28'h0000004, D4);
    waitReady(20, n);
    checkOutput("wr4_latency", n, 4);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    checkOutput("wr4_prot", perr, 1'b0);
    applyStimulus(1'b1, 1'b0, 28'h0000004, '0);
    step();
    applyStimulus(1'b1, 1'b0, 28'h0000005, '0);
    waitReady(20, n);
    checkOutput("addrchg_latency", n, 3);
    checkOutput("addrchg_data", rdata, D4);
    checkOutput("addrchg_prot", perr, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();

    applyStimulus1(1'b0, 1'b1, 28'h0000002, D1);
    step();
    checkOutput("l1_wr_ready", rdy1, 1'b1);
    applyStimulus1(1'b0, 1'b0, '0, '0);
    step();
    checkOutput("l1_wr_one_pulse", rdy1, 1'b0);
    applyStimulus1(1'b1, 1'b0, 28'h0000002, '0);
    step();
    checkOutput("l1_rd_ready", rdy1, 1'b1);
    checkOutput("l1_rd_data", rdata1, D1);
    applyStimulus1(1'b0, 1'b0, '0, '0);
    step();
    applyStimulus1(1'b1, 1'b0, 28'h0000002, '0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rdy1 === 1'b1) pulses++;
    end
    applyStimulus1(1'b0, 1'b0, '0, '0);
    checkOutput("l1_b2b_count", pulses, 10);
    checkOutput("l1_prot", perr1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
